// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO.
// One multiplier or quotient bit per cycle, then a sign-fix cycle.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mthiE,
  input  logic             mtloE,
  input  logic [WIDTH-1:0] wdataE,
  input  logic             abortE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_raw;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_isdiv;
  logic                 r_neg;
  logic                 r_nrem;
  logic                 r_div0;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_maga;
  logic [WIDTH-1:0]     w_magb;
  logic [WIDTH:0]       w_madd;
  logic [WIDTH:0]       w_rsh;
  logic [WIDTH:0]       w_rsub;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_sa   = opE[0] & srcaE[WIDTH-1];
  assign w_sb   = opE[0] & srcbE[WIDTH-1];
  assign w_maga = w_sa ? -srcaE : srcaE;
  assign w_magb = w_sb ? -srcbE : srcbE;

  // acc = {partial product, remaining multiplier bits}
  assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (r_acc[0] ? r_a : {WIDTH{1'b0}})};

  // acc = {partial remainder, dividend bits / quotient bits}
  assign w_rsh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_rsub = w_rsh - {1'b0, r_a};
  assign w_qbit = ~w_rsub[WIDTH];

  assign w_prod = r_neg  ? -r_acc : r_acc;
  assign w_quo  = r_neg  ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_nrem ? -r_acc[2*WIDTH-1:WIDTH]
                         : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_raw   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_isdiv <= 1'b0;
      r_neg   <= 1'b0;
      r_nrem  <= 1'b0;
      r_div0  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (startE && !abortE) begin
            r_state <= opE[1] ? S_DIV : S_MUL;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH);
            r_isdiv <= opE[1];
            r_neg   <= w_sa ^ w_sb;
            r_nrem  <= w_sa;
            r_div0  <= opE[1] & (srcbE == '0);
            r_raw   <= srcaE;
            if (opE[1]) begin
              r_a   <= w_magb;
              r_acc <= {{WIDTH{1'b0}}, w_maga};
            end else begin
              r_a   <= w_maga;
              r_acc <= {{WIDTH{1'b0}}, w_magb};
            end
          end else begin
            if (mthiE) r_hi <= wdataE;
            if (mtloE) r_lo <= wdataE;
          end
        end
        S_MUL, S_DIV: begin
          if (abortE) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_state == S_MUL)
              r_acc <= {w_madd, r_acc[WIDTH-1:1]};
            else
              r_acc <= {(w_qbit ? w_rsub[WIDTH-1:0]
                                : w_rsh[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!abortE) begin
            r_done <= 1'b1;
            if (!r_isdiv) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end else if (r_div0) begin
              r_hi <= r_raw;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the pipelined MIPS core. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers for MFHI/MFLO. It sits beside the ALU in the Execute stage. While an operation is in flight it raises `busy`, and the hazard unit turns that into stallF/stallD/flushE for any dependent instruction. Operand width is parameterised, and each operation takes a fixed number of cycles.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Must be at least 4.
- `CW`, default $clog2(WIDTH+1): iteration counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low. 0 resets the block.
- `startE`  in  1  start request, sampled on the rising edge.
- `opE`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `srcaE`  in  WIDTH  multiplicand or dividend.
- `srcbE`  in  WIDTH  multiplier or divisor.
- `mthiE`, `mtloE`  in  1  HI/LO write strobes.
- `wdataE`  in  WIDTH  data for MTHI/MTLO.
- `abortE`  in  1  cancel the operation in flight (branch flush or exception).
- `hi`, `lo`  out  WIDTH  architectural HI/LO, registered.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO were just updated by an operation.

## Operation
- States: IDLE, MUL, DIV, FIX.
- **IDLE:**
  - `startE`=1: latch the operands, record the signs, and convert to magnitudes for signed ops. Go to MUL (op[1]=0) or DIV (op[1]=1). Set the counter to WIDTH.
  - Else MTHI/MTLO write `wdataE` into HI/LO.
- **MUL:** radix-2 shift-add, one multiplier bit per cycle into a 2·WIDTH accumulator. The counter decrements each cycle. At counter=1, go to FIX.
- **DIV:** restoring division, one quotient bit per cycle. Same counter rule as MUL.
- **FIX:**
  - For signed ops, negate the product if the operand signs differ.
  - The quotient truncates toward zero. The remainder takes the sign of the dividend.
  - Write HI = upper half / remainder and LO = lower half / quotient. Pulse `done`. Go to IDLE.
- **Divide by zero** (either op): LO = all ones, HI = raw `srcaE`. Latency is unchanged, and no error flag is raised.
- **Signed overflow**, −2^(WIDTH−1) / −1: LO = −2^(WIDTH−1) (wrapped), HI = 0.
- `busy` = (state ≠ IDLE).
- **Ignored inputs:**
  - `startE` while busy is ignored; the hazard unit guarantees it does not occur.
  - MTHI/MTLO while busy are ignored.
  - In IDLE, `startE` together with MTHI/MTLO: start wins and the moves are dropped.
- **Abort:** `abortE`=1 in MUL/DIV/FIX returns to IDLE on the next edge. HI/LO are unchanged and there is no `done`. In IDLE, abort has no effect, and abort takes priority over start in the same cycle.
- **Reset:** asserting `reset` at any time, including mid-operation, forces IDLE immediately. HI=0, LO=0, `busy`=0, `done`=0, and the counter and accumulators are 0.

## Timing
- Edge 0 samples `startE`=1; `busy`=1 after edge 0.
- Edges 1..WIDTH are iteration steps. Edge WIDTH+1 is FIX and writes HI/LO.
- After edge WIDTH+1: `busy`=0, `done`=1 for exactly one cycle, and new HI/LO are visible. For WIDTH=32 that is 33 edges after the start edge.
- Back-to-back: a new `startE` may be accepted on the edge right after `done` rises (edge WIDTH+2).
- MTHI/MTLO take effect on the sampling edge, so HI/LO are visible the next cycle.
- `hi`/`lo` are stable throughout an operation and do not show partial results.
- Outputs are glitch-free registers, and no path is combinational from inputs to outputs.

## Test plan
- **MULT:** reset low then high; MULT srcaE=0xFFFFFFFD (−3), srcbE=5 → after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFF1, `done` high for 1 cycle, `busy` low.
- **DIVU and DIV:**
  - DIVU 100/7 → LO=14, HI=2.
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234, latency still 33.
- **Abort:** MULTU 6×7, assert `abortE` at edge 10 → IDLE next edge, HI/LO keep their prior values (preloaded 0xAAAA/0x5555 via MTHI/MTLO), no `done`. An immediate MULTU 6×7 then gives LO=42, HI=0.
- **Start/move conflicts:**
  - `startE` pulsed at edge 5 of a running DIV is ignored; the result matches the original operands.
  - MTLO while busy is ignored.
  - MTHI together with `startE` in IDLE leaves HI equal to the op result.
- **Reset mid-operation:** drive `reset` low at edge 20 of a MULT → `busy` drops asynchronously and HI=LO=0. After release a new MULT completes normally.
